// File: rtl/lamp_fpu_fract_sqrt_gen_pkg.sv
// Shared types and constant generators for the Goldschmidt sqrt / inverse-sqrt unit.
// All fixed-point constants are Q1.(w-1) and are derived per datapath width w.
package lamp_fpu_fract_sqrt_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B,
    ST_R,
    ST_XY,
    ST_FIN,
    ST_DONE
  } sqrt_state_t;

  function automatic logic [63:0] one_q(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Needs w+1 bits: 3.0 does not fit a Q1 format.
  function automatic logic [63:0] three_q(input int w);
    return 64'd3 << (w - 1);
  endfunction

  // floor(sqrt(2) * 2^(w-1)) == isqrt(2^(2w-1)), bitwise integer square root.
  function automatic logic [63:0] sqrt2_q(input int w);
    logic [63:0] n;
    logic [63:0] r;
    logic [63:0] b;
    n = 64'd1 << (2 * w - 1);
    r = 64'd0;
    for (int i = 31; i >= 0; i--) begin
      b = r | (64'd1 << i);
      if (b * b <= n) r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_lzc.sv
// Combinational leading-zero counter; an all-zero input yields DW.
module lamp_fpu_sqrt_lzc #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic [DW-1:0] a,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(DW);
    for (int i = 0; i < DW; i++) begin
      if (a[i]) cnt = CW'(DW - 1 - i);
    end
  end

endmodule

// File: rtl/lamp_fpu_fract_sqrt_gen.sv
// Goldschmidt sqrt / inverse-sqrt of a significand with normalised result and exponent adjust.
// Optional macro LAMP_SQRT_EARLY_EXIT_EN: leave the iteration loop as soon as r has converged to 1.0.
module lamp_fpu_fract_sqrt_gen
  import lamp_fpu_fract_sqrt_gen_pkg::*;
#(
  parameter int F_DW    = 7,
  parameter int PREC_DW = 8,
  parameter int ITERS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [F_DW:0]     s_i,
  input  logic              is_exp_odd_i,
  input  logic              invSqrt_i,
  input  logic              special_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [F_DW+PREC_DW:0] res_o,
  output logic [4:0]        exp_adj_o
);

  localparam int SW  = 1 + F_DW;
  localparam int W   = 1 + F_DW + PREC_DW;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [W-1:0] ONE   = W'(one_q(W));
  localparam logic [W:0]   THREE = (W + 1)'(three_q(W));
  localparam logic [W-1:0] SQRT2 = W'(sqrt2_q(W));

  // Handshake: an operand transfers on a rising edge with valid_i & ready_o;
  // a result transfers on a rising edge with valid_o & ready_i; valid_o and
  // the result stay stable until that transfer.

  sqrt_state_t state_q, state_d;
  logic [W-1:0]   b_q, r_q, x_q, y_q, res_q;
  logic [4:0]     adj_q;
  logic [3:0]     cnt_q;
  logic [LZW-1:0] lz, lz_q;
  logic           odd_q, inv_q;

  function automatic logic [W-1:0] mul_q(input logic [W-1:0] a, input logic [W-1:0] c);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, c};
    return W'(p >> (W - 1));
  endfunction

  function automatic logic [W-1:0] half3(input logic [W-1:0] v);
    logic [W:0] d;
    d = THREE - {1'b0, v};
    return W'(d >> 1);
  endfunction

  lamp_fpu_sqrt_lzc #(.DW(SW), .CW(LZW)) u_lzc (
    .a   (s_i),
    .cnt (lz)
  );

  // Seeding happens on the accept edge, so the first busy cycle is already B.
  logic [W-1:0] f_init, r_init, x_init;
  logic [W-1:0] b_next, r_next, x_next, y_next;
  always_comb begin
    f_init = {s_i, {PREC_DW{1'b0}}} << lz;
    r_init = half3(f_init);
    x_init = mul_q(f_init, r_init);
    b_next = mul_q(mul_q(b_q, r_q), r_q);
    r_next = half3(b_q);
    x_next = mul_q(x_q, r_q);
    y_next = mul_q(y_q, r_q);
  end

  logic signed [4:0] e, e_even, half_e, adj;
  logic [W-1:0] base, prod, res_fin;
  always_comb begin
    e      = $signed({4'd0, odd_q}) - $signed(5'(lz_q));
    base   = inv_q ? y_q : x_q;
    prod   = base;
    e_even = e;
    // Odd exponent: pull one factor of sqrt(2) into the mantissa; the
    // inverse root needs 2^-1/2 = sqrt(2)/2, hence the opposite step.
    if (e[0]) begin
      prod   = mul_q(base, SQRT2);
      e_even = inv_q ? e + 5'sd1 : e - 5'sd1;
    end
    half_e  = e_even >>> 1;
    adj     = inv_q ? -half_e : half_e;
    res_fin = prod;
    if (!prod[W-1]) begin
      res_fin = prod << 1;
      adj     = adj - 5'sd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = special_i ? ST_DONE : ST_B;
`ifdef LAMP_SQRT_EARLY_EXIT_EN
      ST_B:    state_d = (r_q == ONE) ? ST_FIN : ST_R;
`else
      ST_B:    state_d = ST_R;
`endif
      ST_R:    state_d = ST_XY;
      ST_XY:   state_d = (cnt_q == 4'(ITERS - 1)) ? ST_FIN : ST_B;
      ST_FIN:  state_d = ST_DONE;
      ST_DONE: if (ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q   <= '0;
      r_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      res_q <= '0;
      adj_q <= '0;
      cnt_q <= '0;
      lz_q  <= '0;
      odd_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (valid_i) begin
          odd_q <= is_exp_odd_i;
          inv_q <= invSqrt_i;
          lz_q  <= lz;
          b_q   <= f_init;
          r_q   <= r_init;
          y_q   <= r_init;
          x_q   <= x_init;
          cnt_q <= '0;
          if (special_i) begin
            res_q <= '0;
            adj_q <= '0;
          end
        end
        ST_B:  b_q <= b_next;
        ST_R:  r_q <= r_next;
        ST_XY: begin
          x_q   <= x_next;
          y_q   <= y_next;
          cnt_q <= cnt_q + 4'd1;
        end
        ST_FIN: begin
          res_q <= res_fin;
          adj_q <= adj;
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = (state_q == ST_IDLE) && !rst;
  assign valid_o   = (state_q == ST_DONE);
  assign res_o     = res_q;
  assign exp_adj_o = adj_q;

endmodule
